// File: rtl/wb_retire_unit.sv
// Writeback/retire stage: load alignment, regfile write port, WB->ID forwarding,
// commit trace and retire counters. Define WB_PERF_CNT_EN to build the control/mispredict counters.
`timescale 1ns/1ps
module wb_retire_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64,
    parameter int EVT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_stall,
    input  logic             i_cnt_clr,
    input  logic [XLEN-1:0]  i_pc,
    input  logic [XLEN-1:0]  i_alu_result,
    input  logic [XLEN-1:0]  i_rdata,
    input  logic [4:0]       i_rd,
    input  logic             i_ctrl_valid,
    input  logic             i_ctrl_bubble,
    input  logic             i_ctrl_wb_en,
    input  logic             i_ctrl_mem_read,
    input  logic             i_ctrl_mispred,
    input  logic             i_ctrl_is_control,
    input  logic [2:0]       i_ctrl_funct3,
    output logic             o_rf_we,
    output logic [4:0]       o_rf_waddr,
    output logic [XLEN-1:0]  o_rf_wdata,
    output logic             o_fwd_valid,
    output logic [4:0]       o_fwd_rd,
    output logic [XLEN-1:0]  o_fwd_data,
    output logic             o_commit_valid,
    output logic [XLEN-1:0]  o_commit_pc,
    output logic             o_commit_mispred,
    output logic [CNT_W-1:0] o_cycle_cnt,
    output logic [CNT_W-1:0] o_instret_cnt,
    output logic [EVT_W-1:0] o_ctrl_cnt,
    output logic [EVT_W-1:0] o_mispred_cnt
);

    function automatic logic [XLEN-1:0] load_align(input logic [XLEN-1:0] word,
                                                   input logic [1:0]      off,
                                                   input logic [2:0]      f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [XLEN-1:0] res;
        unique case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        // off[0] is deliberately ignored for halfwords; misalignment is trapped upstream.
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  res = {{(XLEN-8){b[7]}}, b};
            3'b100:  res = {{(XLEN-8){1'b0}}, b};
            3'b001:  res = {{(XLEN-16){h[15]}}, h};
            3'b101:  res = {{(XLEN-16){1'b0}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    logic live;
    logic retire;

    // An instruction is counted only on its final cycle in MEM/WB, so stalls never double-count.
    assign live   = i_ctrl_valid & ~i_ctrl_bubble;
    assign retire = live & ~i_stall;

    always_comb begin
        o_rf_we    = live & i_ctrl_wb_en & (i_rd != 5'd0);
        o_rf_waddr = i_rd;
        o_rf_wdata = i_ctrl_mem_read ? load_align(i_rdata, i_alu_result[1:0], i_ctrl_funct3)
                                     : i_alu_result;
    end

    logic             fwd_valid_q;
    logic [4:0]       fwd_rd_q;
    logic [XLEN-1:0]  fwd_data_q;
    logic             commit_valid_q;
    logic [XLEN-1:0]  commit_pc_q;
    logic             commit_mispred_q;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    always_comb begin
        cycle_d   = cycle_q + CNT_W'(1);
        instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
        if (i_cnt_clr) begin
            cycle_d   = '0;
            instret_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            fwd_valid_q      <= 1'b0;
            fwd_rd_q         <= '0;
            fwd_data_q       <= '0;
            commit_valid_q   <= 1'b0;
            commit_pc_q      <= '0;
            commit_mispred_q <= 1'b0;
            cycle_q          <= '0;
            instret_q        <= '0;
        end else begin
            if (!i_stall) begin
                fwd_valid_q <= o_rf_we;
                fwd_rd_q    <= i_rd;
                fwd_data_q  <= o_rf_wdata;
            end
            commit_valid_q <= retire;
            if (retire) begin
                commit_pc_q      <= i_pc;
                commit_mispred_q <= i_ctrl_mispred;
            end
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    assign o_fwd_valid      = fwd_valid_q;
    assign o_fwd_rd         = fwd_rd_q;
    assign o_fwd_data       = fwd_data_q;
    assign o_commit_valid   = commit_valid_q;
    assign o_commit_pc      = commit_pc_q;
    assign o_commit_mispred = commit_mispred_q;
    assign o_cycle_cnt      = cycle_q;
    assign o_instret_cnt    = instret_q;

`ifdef WB_PERF_CNT_EN
    logic [EVT_W-1:0] ctrl_q, ctrl_d;
    logic [EVT_W-1:0] mispred_q, mispred_d;

    // A mispredict flag counts even without is_control set.
    always_comb begin
        ctrl_d    = (retire & i_ctrl_is_control) ? ctrl_q + EVT_W'(1) : ctrl_q;
        mispred_d = (retire & i_ctrl_mispred) ? mispred_q + EVT_W'(1) : mispred_q;
        if (i_cnt_clr) begin
            ctrl_d    = '0;
            mispred_d = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            ctrl_q    <= '0;
            mispred_q <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            mispred_q <= mispred_d;
        end
    end

    assign o_ctrl_cnt    = ctrl_q;
    assign o_mispred_cnt = mispred_q;
`else
    logic perf_unused;
    assign perf_unused   = i_ctrl_is_control;
    assign o_ctrl_cnt    = '0;
    assign o_mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_wb_retire_unit.sv
// Directed self-checking bench for wb_retire_unit; a second 4-bit-counter instance
// shares the stimulus so counter wrap can be reached in a few cycles.
`timescale 1ns/1ps
module tb_wb_retire_unit;

`ifdef WB_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        stall, cnt_clr;
    logic [31:0] pc, alu, rdata;
    logic [4:0]  rd;
    logic        valid, bubble, wb_en, mem_read, mispred, is_ctl;
    logic [2:0]  f3;

    logic        rf_we, fwd_valid, commit_valid, commit_mispred;
    logic [4:0]  rf_waddr, fwd_rd;
    logic [31:0] rf_wdata, fwd_data, commit_pc;
    logic [63:0] cycle_cnt, instret_cnt;
    logic [31:0] ctrl_cnt, mispred_cnt;

    logic        s_rf_we, s_fwd_valid, s_commit_valid, s_commit_mispred;
    logic [4:0]  s_rf_waddr, s_fwd_rd;
    logic [31:0] s_rf_wdata, s_fwd_data, s_commit_pc;
    logic [3:0]  s_cycle_cnt, s_instret_cnt, s_ctrl_cnt, s_mispred_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    wb_retire_unit dut (
        .i_clk(clk), .i_reset(rst_n), .i_stall(stall), .i_cnt_clr(cnt_clr),
        .i_pc(pc), .i_alu_result(alu), .i_rdata(rdata), .i_rd(rd),
        .i_ctrl_valid(valid), .i_ctrl_bubble(bubble), .i_ctrl_wb_en(wb_en),
        .i_ctrl_mem_read(mem_read), .i_ctrl_mispred(mispred),
        .i_ctrl_is_control(is_ctl), .i_ctrl_funct3(f3),
        .o_rf_we(rf_we), .o_rf_waddr(rf_waddr), .o_rf_wdata(rf_wdata),
        .o_fwd_valid(fwd_valid), .o_fwd_rd(fwd_rd), .o_fwd_data(fwd_data),
        .o_commit_valid(commit_valid), .o_commit_pc(commit_pc),
        .o_commit_mispred(commit_mispred), .o_cycle_cnt(cycle_cnt),
        .o_instret_cnt(instret_cnt), .o_ctrl_cnt(ctrl_cnt), .o_mispred_cnt(mispred_cnt)
    );

    wb_retire_unit #(.XLEN(32), .CNT_W(4), .EVT_W(4)) dut_small (
        .i_clk(clk), .i_reset(rst_n), .i_stall(stall), .i_cnt_clr(cnt_clr),
        .i_pc(pc), .i_alu_result(alu), .i_rdata(rdata), .i_rd(rd),
        .i_ctrl_valid(valid), .i_ctrl_bubble(bubble), .i_ctrl_wb_en(wb_en),
        .i_ctrl_mem_read(mem_read), .i_ctrl_mispred(mispred),
        .i_ctrl_is_control(is_ctl), .i_ctrl_funct3(f3),
        .o_rf_we(s_rf_we), .o_rf_waddr(s_rf_waddr), .o_rf_wdata(s_rf_wdata),
        .o_fwd_valid(s_fwd_valid), .o_fwd_rd(s_fwd_rd), .o_fwd_data(s_fwd_data),
        .o_commit_valid(s_commit_valid), .o_commit_pc(s_commit_pc),
        .o_commit_mispred(s_commit_mispred), .o_cycle_cnt(s_cycle_cnt),
        .o_instret_cnt(s_instret_cnt), .o_ctrl_cnt(s_ctrl_cnt), .o_mispred_cnt(s_mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic wb, input logic mr, input logic mp,
                         input logic ctl, input logic [2:0] fn, input logic [4:0] dst,
                         input logic [31:0] p, input logic [31:0] a, input logic [31:0] d,
                         input logic st, input logic clr);
        valid = v; bubble = 1'b0; wb_en = wb; mem_read = mr; mispred = mp; is_ctl = ctl;
        f3 = fn; rd = dst; pc = p; alu = a; rdata = d; stall = st; cnt_clr = clr;
    endtask

    task automatic idle(input logic clr);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, clr);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle(1'b0);
        #2;
        n_tests++; if (fwd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fwd_valid got %0b want 0", fwd_valid); end
        n_tests++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL reset_commit_valid got %0b want 0", commit_valid); end
        n_tests++; if (cycle_cnt !== 64'd0) begin n_fail++; $display("FAIL reset_cycle got %0d want 0", cycle_cnt); end
        n_tests++; if (instret_cnt !== 64'd0) begin n_fail++; $display("FAIL reset_instret got %0d want 0", instret_cnt); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (cycle_cnt !== 64'd1) begin n_fail++; $display("FAIL reset_first_cycle got %0d want 1", cycle_cnt); end
    endtask

    task automatic test_load_byte;
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 5'd5, 32'h10, 32'h0000_0103, 32'h80FF_7F01, 1'b0, 1'b0);
        #1;
        n_tests++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL lb_we got %0b want 1", rf_we); end
        n_tests++; if (rf_waddr !== 5'd5) begin n_fail++; $display("FAIL lb_waddr got %0d want 5", rf_waddr); end
        n_tests++; if (rf_wdata !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_data got %h want ffffff80", rf_wdata); end
        @(posedge clk); #1;
        n_tests++; if (fwd_valid !== 1'b1 || fwd_rd !== 5'd5 || fwd_data !== 32'hFFFF_FF80) begin
            n_fail++; $display("FAIL lb_fwd got %0b/%0d/%h want 1/5/ffffff80", fwd_valid, fwd_rd, fwd_data); end
        n_tests++; if (commit_valid !== 1'b1 || commit_pc !== 32'h10) begin
            n_fail++; $display("FAIL lb_commit got %0b/%h want 1/00000010", commit_valid, commit_pc); end
        @(negedge clk); f3 = 3'b100; #1;
        n_tests++; if (rf_wdata !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_data got %h want 00000080", rf_wdata); end
        f3 = 3'b000; alu = 32'h0000_0101; #1;
        n_tests++; if (rf_wdata !== 32'h0000_007F) begin n_fail++; $display("FAIL lb_off1_data got %h want 0000007f", rf_wdata); end
    endtask

    task automatic test_load_half;
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'b001, 5'd6, 32'h14, 32'h0000_0002, 32'h8001_1234, 1'b0, 1'b0);
        #1;
        n_tests++; if (rf_wdata !== 32'hFFFF_8001) begin n_fail++; $display("FAIL lh_data got %h want ffff8001", rf_wdata); end
        f3 = 3'b101; alu = 32'h0000_0000; #1;
        n_tests++; if (rf_wdata !== 32'h0000_1234) begin n_fail++; $display("FAIL lhu_data got %h want 00001234", rf_wdata); end
        f3 = 3'b011; #1;
        n_tests++; if (rf_wdata !== 32'h8001_1234) begin n_fail++; $display("FAIL f3_011_data got %h want 80011234", rf_wdata); end
        mem_read = 1'b0; alu = 32'hDEAD_BEEF; #1;
        n_tests++; if (rf_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL alu_data got %h want deadbeef", rf_wdata); end
        bubble = 1'b1; #1;
        n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL bubble_we got %0b want 0", rf_we); end
        @(posedge clk);
    endtask

    task automatic test_rd_zero;
        @(negedge clk); idle(1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 5'd0, 32'h20, 32'h1234_5678, 32'h0, 1'b0, 1'b0);
        #1;
        n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL rd0_we got %0b want 0", rf_we); end
        @(posedge clk); #1;
        n_tests++; if (fwd_valid !== 1'b0) begin n_fail++; $display("FAIL rd0_fwd_valid got %0b want 0", fwd_valid); end
        n_tests++; if (commit_valid !== 1'b1 || commit_pc !== 32'h20) begin
            n_fail++; $display("FAIL rd0_commit got %0b/%h want 1/00000020", commit_valid, commit_pc); end
        n_tests++; if (instret_cnt !== 64'd1 || cycle_cnt !== 64'd1) begin
            n_fail++; $display("FAIL rd0_counts got %0d/%0d want 1/1", instret_cnt, cycle_cnt); end
    endtask

    task automatic test_stall_retire;
        @(negedge clk); idle(1'b1);
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'b010, 5'd0, 32'h40, 32'h0, 32'h0, 1'b1, 1'b0);
            @(posedge clk); #1;
            n_tests++; if (commit_valid !== 1'b0 || instret_cnt !== 64'd0) begin
                n_fail++; $display("FAIL stall%0d got commit %0b instret %0d want 0/0", k, commit_valid, instret_cnt); end
        end
        @(negedge clk); stall = 1'b0;
        @(posedge clk); #1;
        n_tests++; if (commit_valid !== 1'b1 || commit_pc !== 32'h40 || commit_mispred !== 1'b1) begin
            n_fail++; $display("FAIL stall_release_commit got %0b/%h/%0b want 1/00000040/1", commit_valid, commit_pc, commit_mispred); end
        n_tests++; if (instret_cnt !== 64'd1) begin n_fail++; $display("FAIL stall_instret got %0d want 1", instret_cnt); end
        n_tests++; if (ctrl_cnt !== (PERF ? 32'd1 : 32'd0) || mispred_cnt !== (PERF ? 32'd1 : 32'd0)) begin
            n_fail++; $display("FAIL stall_evt got %0d/%0d want %0d/%0d", ctrl_cnt, mispred_cnt, PERF, PERF); end
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b010, 5'd0, 32'h44, 32'h0, 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        n_tests++; if (ctrl_cnt !== (PERF ? 32'd1 : 32'd0) || mispred_cnt !== (PERF ? 32'd2 : 32'd0)) begin
            n_fail++; $display("FAIL mispred_noctl_evt got %0d/%0d want %0d/%0d", ctrl_cnt, mispred_cnt, PERF ? 1 : 0, PERF ? 2 : 0); end
        @(negedge clk); idle(1'b0);
        @(posedge clk); #1;
        n_tests++; if (commit_valid !== 1'b0 || commit_pc !== 32'h44 || instret_cnt !== 64'd2) begin
            n_fail++; $display("FAIL idle_hold got %0b/%h/%0d want 0/00000044/2", commit_valid, commit_pc, instret_cnt); end
    endtask

    task automatic test_wrap_clear;
        @(negedge clk); idle(1'b1);
        @(posedge clk);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'b010, 5'd0, 32'h100 + 32'(i), 32'h0, 32'h0, 1'b0, 1'b0);
            @(posedge clk); #1;
            if (i == 15) begin
                n_tests++; if (s_instret_cnt !== 4'hF || s_mispred_cnt !== (PERF ? 4'hF : 4'h0)) begin
                    n_fail++; $display("FAIL wrap_pre got %0d/%0d want 15/%0d", s_instret_cnt, s_mispred_cnt, PERF ? 15 : 0); end
            end
            if (i == 16) begin
                n_tests++; if (s_instret_cnt !== 4'h0 || s_ctrl_cnt !== 4'h0) begin
                    n_fail++; $display("FAIL wrap_zero got %0d/%0d want 0/0", s_instret_cnt, s_ctrl_cnt); end
                n_tests++; if (instret_cnt !== 64'd16) begin n_fail++; $display("FAIL wrap_wide got %0d want 16", instret_cnt); end
            end
        end
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 5'd7, 32'h80, 32'h55, 32'h0, 1'b0, 1'b1);
        @(posedge clk); #1;
        n_tests++; if (cycle_cnt !== 64'd0 || instret_cnt !== 64'd0 || ctrl_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin
            n_fail++; $display("FAIL clr_counts got %0d/%0d/%0d/%0d want 0/0/0/0", cycle_cnt, instret_cnt, ctrl_cnt, mispred_cnt); end
        n_tests++; if (commit_valid !== 1'b1 || commit_pc !== 32'h80 || fwd_valid !== 1'b1 || fwd_data !== 32'h55) begin
            n_fail++; $display("FAIL clr_trace got %0b/%h/%0b/%h want 1/00000080/1/00000055", commit_valid, commit_pc, fwd_valid, fwd_data); end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 5'd3, 32'h90, 32'h99, 32'h0, 1'b1, 1'b0);
        @(posedge clk); #1;
        n_tests++; if (fwd_valid !== 1'b1 || fwd_rd !== 5'd7 || fwd_data !== 32'h55 || commit_valid !== 1'b0) begin
            n_fail++; $display("FAIL stall_fwd_hold got %0b/%0d/%h/%0b want 1/7/00000055/0", fwd_valid, fwd_rd, fwd_data, commit_valid); end
        #2; rst_n = 1'b0; #1;
        n_tests++; if (fwd_valid !== 1'b0 || fwd_data !== 32'h0 || commit_pc !== 32'h0 || commit_mispred !== 1'b0) begin
            n_fail++; $display("FAIL async_regs got %0b/%h/%h/%0b want 0/0/0/0", fwd_valid, fwd_data, commit_pc, commit_mispred); end
        n_tests++; if (cycle_cnt !== 64'd0 || instret_cnt !== 64'd0) begin
            n_fail++; $display("FAIL async_counts got %0d/%0d want 0/0", cycle_cnt, instret_cnt); end
        n_tests++; if (rf_we !== 1'b1 || rf_wdata !== 32'h99) begin
            n_fail++; $display("FAIL async_comb got %0b/%h want 1/00000099", rf_we, rf_wdata); end
        @(negedge clk); idle(1'b0); rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        n_tests++; if (cycle_cnt !== 64'd10 || instret_cnt !== 64'd0 || commit_valid !== 1'b0) begin
            n_fail++; $display("FAIL post_reset got %0d/%0d/%0b want 10/0/0", cycle_cnt, instret_cnt, commit_valid); end
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_load_half();
        test_rd_zero();
        test_stall_retire();
        test_wrap_clear();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
